// File: rtl/pip_pkg.sv
`timescale 1ns/1ps
// pip_pkg: shared types and constants for the MEM->WB pipeline register.
//   XLEN, REG_ADDR_W, WB_SEL_W  default payload field widths
//   pip_state_e                 occupancy state of the skid buffer
//   mem_wb_payload_t            field layout of one MEM->WB beat, MSB first
//   payload_width()             flat width of a beat for arbitrary field widths
package pip_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_SEL_W   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pip_state_e;

    // The parametrised top packs its flat payload vector in exactly this
    // field order, so for default widths a beat casts directly to this type.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       alu_res;
        logic [XLEN-1:0]       sign_immediate;
        logic [XLEN-1:0]       data_mem_res;
        logic                  reg_write_en;
        logic [WB_SEL_W-1:0]   write_back_mux;
    } mem_wb_payload_t;

    function automatic int payload_width(input int data_w, input int addr_w, input int sel_w);
        return 4 * data_w + addr_w + 1 + sel_w;
    endfunction

endpackage

// File: rtl/pip_skid_buf.sv
`timescale 1ns/1ps
// pip_skid_buf: payload-agnostic valid/ready register with an optional
// second (skid) entry.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1. A producer holding valid=1 keeps its data stable
// until that edge; this block never drops valid or changes out_data while
// out_ready=0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous discard of held and incoming beats
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (registered)
//   state                current occupancy, exposed for checkers
//
// SKID_EN=1: in_ready is a flop (state != FULL), no path from out_ready.
// SKID_EN=0: single entry, in_ready = ~out_valid | out_ready.
module pip_skid_buf
    import pip_pkg::*;
#(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output pip_state_e   state
);

    pip_state_e   state_q;
    pip_state_e   state_d;
    logic         ready_q;
    logic         ready_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         consume;
    logic         load_main;
    logic         load_skid;
    logic         pop_skid;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // ready_q is 0 in reset, so in_ready rises one edge after rst_n releases.
    // In the skid build it also carries the registered "not FULL" decode.
    assign ready_d  = SKID_EN ? (state_d != FULL) : 1'b1;
    assign in_ready = SKID_EN ? ready_q : (ready_q & (~out_valid | out_ready));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Next state; flush wins over any accept or consume.
    // FULL is unreachable with SKID_EN=0: there accept in BUSY implies consume.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = BUSY;
                BUSY: begin
                    if (accept && !consume)      state_d = FULL;
                    else if (!accept && consume) state_d = EMPTY;
                end
                FULL:    if (consume) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs and datapath controls
    always_comb begin
        out_valid = (state_q != EMPTY);
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: load_main = accept;
                BUSY: begin
                    load_main = accept & consume;
                    load_skid = accept & ~consume;
                end
                FULL:    pop_skid = consume;
                default: ;
            endcase
        end
    end

    // Payload storage; stale data after a flush or drain is harmless because
    // out_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)     main_q <= in_data;
            else if (pop_skid) main_q <= skid_q;
            if (load_skid)     skid_q <= in_data;
        end
    end

    assign out_data = main_q;
    assign state    = state_q;

endmodule

// File: rtl/pip_reg4_hs.sv
`timescale 1ns/1ps
// pip_reg4_hs: MEM->WB pipeline register with valid/ready handshake,
// optional 2-entry skid, synchronous flush and x0 write suppression.
//
// Ports:
//   clk, rst_n, flush                 clock, async active-low reset, sync kill
//   in_valid/in_ready                 upstream (MEM) handshake
//   rd_in, pc_in, alu_res_in, sign_immediate_in, data_mem_res_in,
//   reg_write_en_in, write_back_mux_in   incoming payload
//   out_valid/out_ready               downstream (WB) handshake
//   rd_out ... write_back_mux_out     registered payload
module pip_reg4_hs
    import pip_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WB_SEL_WIDTH   = 2,
    parameter bit SKID_EN        = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    input  logic [DATA_WIDTH-1:0]     pc_in,
    input  logic [DATA_WIDTH-1:0]     alu_res_in,
    input  logic [DATA_WIDTH-1:0]     sign_immediate_in,
    input  logic [DATA_WIDTH-1:0]     data_mem_res_in,
    input  logic                      reg_write_en_in,
    input  logic [WB_SEL_WIDTH-1:0]   write_back_mux_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic [DATA_WIDTH-1:0]     pc_out,
    output logic [DATA_WIDTH-1:0]     alu_res_out,
    output logic [DATA_WIDTH-1:0]     sign_immediate_out,
    output logic [DATA_WIDTH-1:0]     data_mem_res_out,
    output logic                      reg_write_en_out,
    output logic [WB_SEL_WIDTH-1:0]   write_back_mux_out
);

    localparam int PW = payload_width(DATA_WIDTH, REG_ADDR_WIDTH, WB_SEL_WIDTH);

    logic [PW-1:0] in_data;
    logic [PW-1:0] out_data;
    logic          we_masked;
    logic          stored_we;
    pip_state_e    buf_state;

    // Writes to x0 are dropped before storage, so the held beat is already
    // clean and WB never sees a write enable for rd=0.
    assign we_masked = reg_write_en_in & (rd_in != '0);

    // Field order matches mem_wb_payload_t.
    assign in_data = {rd_in, pc_in, alu_res_in, sign_immediate_in,
                      data_mem_res_in, we_masked, write_back_mux_in};

    pip_skid_buf #(
        .W       (PW),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .state     (buf_state)
    );

    assign {rd_out, pc_out, alu_res_out, sign_immediate_out,
            data_mem_res_out, stored_we, write_back_mux_out} = out_data;

    // The payload may be stale once the buffer empties (drain or flush);
    // the write enable must never outlive the beat that owns it.
    assign reg_write_en_out = stored_we & (buf_state != EMPTY);

endmodule
